// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the register-file write port between the
// execute pipe (P) and the long-latency unit (M). Optional perf counters: WB_ARB_PERF_EN.
module wb_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            p_valid,
  output logic            p_ready,
  input  logic [4:0]      p_rd,
  input  logic [XLEN-1:0] p_data,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [4:0]      m_rd,
  input  logic [XLEN-1:0] m_data,
  output logic            wb_valid,
  output logic [4:0]      wb_dest_addr,
  output logic [XLEN-1:0] wb_dest_data,
  output logic            wb_commit,
`ifdef WB_ARB_PERF_EN
  output logic            wb_src_m,
  output logic [63:0]     perf_conflict_cnt,
  output logic [63:0]     perf_force_cnt
`else
  output logic            wb_src_m
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_m;
  logic             grant_p;
  logic             grant_m;

  // Readies are gated by reset so nothing transfers while the requesters are being reset.
  always_comb begin
    force_m = p_valid && m_valid && (starve_cnt >= LIMIT);
    grant_p = !reset && p_valid && !force_m;
    grant_m = !reset && m_valid && (!p_valid || force_m);
  end

  assign p_ready = grant_p;
  assign m_ready = grant_m;

  always_ff @(posedge clock) begin
    if (reset || !m_valid || grant_m) begin
      starve_cnt <= '0;
    end else if (starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Address/data/source hold on idle cycles; rd==0 still commits but never writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_commit    <= 1'b0;
      wb_dest_addr <= '0;
      wb_dest_data <= '0;
      wb_src_m     <= 1'b0;
    end else begin
      wb_commit <= grant_p || grant_m;
      if (grant_m) begin
        wb_valid     <= (m_rd != 5'd0);
        wb_dest_addr <= m_rd;
        wb_dest_data <= m_data;
        wb_src_m     <= 1'b1;
      end else if (grant_p) begin
        wb_valid     <= (p_rd != 5'd0);
        wb_dest_addr <= p_rd;
        wb_dest_data <= p_data;
        wb_src_m     <= 1'b0;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_conflict_cnt <= '0;
      perf_force_cnt    <= '0;
    end else begin
      if (p_valid && m_valid) perf_conflict_cnt <= perf_conflict_cnt + 64'd1;
      if (grant_m && p_valid) perf_force_cnt    <= perf_force_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a reference model predicts grants and
// queues expected writeback outputs, which a monitor compares one cycle later.
module tb_wb_port_arbiter;

  localparam int XLEN  = 64;
  localparam int LIMIT = 4;

  typedef struct {
    logic            commit;
    logic            valid;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic            src;
  } wb_exp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            p_valid = 1'b0, m_valid = 1'b0;
  logic            p_ready, m_ready;
  logic [4:0]      p_rd = '0, m_rd = '0;
  logic [XLEN-1:0] p_data = '0, m_data = '0;
  logic            wb_valid, wb_commit, wb_src_m;
  logic [4:0]      wb_dest_addr;
  logic [XLEN-1:0] wb_dest_data;
`ifdef WB_ARB_PERF_EN
  logic [63:0]     perf_conflict_cnt, perf_force_cnt;
  logic [63:0]     model_conflict = '0, model_force = '0;
`endif

  int errors = 0;
  int checks = 0;

  wb_exp_t         sb[$];
  int              model_cnt = 0;
  logic [4:0]      last_addr = '0;
  logic [XLEN-1:0] last_data = '0;
  logic            last_src = 1'b0;

  wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .p_valid(p_valid), .p_ready(p_ready), .p_rd(p_rd), .p_data(p_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
    .wb_valid(wb_valid), .wb_dest_addr(wb_dest_addr), .wb_dest_data(wb_dest_data),
    .wb_commit(wb_commit),
`ifdef WB_ARB_PERF_EN
    .wb_src_m(wb_src_m),
    .perf_conflict_cnt(perf_conflict_cnt), .perf_force_cnt(perf_force_cnt)
`else
    .wb_src_m(wb_src_m)
`endif
  );

  always #5 clock = ~clock;

  // Issue scoreboard guarantees no shared nonzero rd in flight between P and M.
  always @(posedge clock) begin
    if (!reset && p_valid && m_valid && p_rd != 5'd0 && p_rd == m_rd) begin
      errors++;
      $display("[TB] FAIL rd_collision: both valid with rd=%0d, required distinct", p_rd);
    end
  end

  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      wb_exp_t e;
      e = sb.pop_front();
      checks += 5;
      if (wb_commit !== e.commit) begin
        errors++; $display("[TB] FAIL wb_commit: got %b, expected %b", wb_commit, e.commit);
      end
      if (wb_valid !== e.valid) begin
        errors++; $display("[TB] FAIL wb_valid: got %b, expected %b", wb_valid, e.valid);
      end
      if (wb_dest_addr !== e.addr) begin
        errors++; $display("[TB] FAIL wb_dest_addr: got %0d, expected %0d", wb_dest_addr, e.addr);
      end
      if (wb_dest_data !== e.data) begin
        errors++; $display("[TB] FAIL wb_dest_data: got %h, expected %h", wb_dest_data, e.data);
      end
      if (wb_src_m !== e.src) begin
        errors++; $display("[TB] FAIL wb_src_m: got %b, expected %b", wb_src_m, e.src);
      end
    end
  end

  task automatic drive_reset();
    wb_exp_t e;
    @(negedge clock);
    reset = 1'b1;
    #1;
    e = '{commit: 1'b0, valid: 1'b0, addr: 5'd0, data: '0, src: 1'b0};
    sb.push_back(e);
    model_cnt = 0;
    last_addr = '0; last_data = '0; last_src = 1'b0;
`ifdef WB_ARB_PERF_EN
    model_conflict = '0; model_force = '0;
`endif
  endtask

  // Drives one cycle of requests and queues what the model says the output stage shows next.
  task automatic drive_cycle(input logic pv, input logic [4:0] prd, input logic [XLEN-1:0] pd,
                             input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] md,
                             output logic ep, output logic em);
    wb_exp_t e;
    logic    frc;
    @(negedge clock);
    reset = 1'b0;
    p_valid = pv; p_rd = prd; p_data = pd;
    m_valid = mv; m_rd = mrd; m_data = md;
    #1;
    frc = pv && mv && (model_cnt >= LIMIT);
    ep  = pv && !frc;
    em  = mv && (!pv || frc);
    if (em) begin
      last_addr = mrd; last_data = md; last_src = 1'b1;
    end else if (ep) begin
      last_addr = prd; last_data = pd; last_src = 1'b0;
    end
    e.commit = ep || em;
    e.valid  = (ep || em) && (last_addr != 5'd0);
    e.addr   = last_addr;
    e.data   = last_data;
    e.src    = last_src;
    sb.push_back(e);
    if (!mv || em) model_cnt = 0;
    else if (model_cnt < LIMIT) model_cnt++;
`ifdef WB_ARB_PERF_EN
    if (pv && mv) model_conflict++;
    if (em && pv) model_force++;
`endif
  endtask

  task automatic idle(input int n);
    logic ep, em;
    for (int i = 0; i < n; i++) drive_cycle(0, 5'd0, '0, 0, 5'd0, '0, ep, em);
  endtask

  task automatic test_reset();
    drive_reset();
    checks += 2;
    if (p_ready !== 1'b0 || m_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready: got p=%b m=%b, expected 0/0", p_ready, m_ready);
    end
    @(posedge clock); #2;
    if (dut.starve_cnt !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_starve: got %0d, expected 0", dut.starve_cnt);
    end
  endtask

  task automatic test_single_p();
    logic ep, em;
    idle(1);
    drive_cycle(1, 5'd5, 64'h1234, 0, 5'd0, '0, ep, em);
    checks += 2;
    if (p_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL single_p_ready: got %b, expected 1", p_ready);
    end
    if (m_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL single_m_ready: got %b, expected 0", m_ready);
    end
    idle(1);
  endtask

  task automatic test_rd_zero();
    logic ep, em;
    drive_cycle(0, 5'd0, '0, 1, 5'd0, 64'hDEAD, ep, em);
    checks++;
    if (m_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rd_zero_m_ready: got %b, expected 1", m_ready);
    end
    idle(1);
  endtask

  task automatic test_conflict();
    logic ep, em;
    idle(1);
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1, 5'(10 + c), 64'(100 + c), 1, 5'd9, 64'hABCD, ep, em);
      checks += 2;
      if (m_ready !== (c == 4)) begin
        errors++; $display("[TB] FAIL conflict_m_ready c%0d: got %b, expected %b", c, m_ready, (c == 4));
      end
      if (p_ready !== (c != 4)) begin
        errors++; $display("[TB] FAIL conflict_p_ready c%0d: got %b, expected %b", c, p_ready, (c != 4));
      end
      if (c == 5) begin
        checks += 2;
        if (wb_dest_addr !== 5'd9) begin
          errors++; $display("[TB] FAIL conflict_addr: got %0d, expected 9", wb_dest_addr);
        end
        if (dut.starve_cnt !== 4'd0) begin
          errors++; $display("[TB] FAIL conflict_starve: got %0d, expected 0", dut.starve_cnt);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_m_drop();
    logic ep, em, mv;
    idle(1);
    for (int c = 0; c < 10; c++) begin
      mv = (c < 3) || (c >= 5);
      drive_cycle(1, 5'(20 + c), 64'(200 + c), mv, 5'd9, 64'h5555, ep, em);
      checks++;
      if (m_ready !== (c == 9)) begin
        errors++; $display("[TB] FAIL m_drop_m_ready c%0d: got %b, expected %b", c, m_ready, (c == 9));
      end
      if (c == 4) begin
        checks++;
        if (dut.starve_cnt !== 4'd0) begin
          errors++; $display("[TB] FAIL m_drop_starve: got %0d, expected 0", dut.starve_cnt);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    logic ep, em;
    idle(1);
    for (int c = 0; c < 3; c++) drive_cycle(1, 5'(1 + c), 64'(c), 1, 5'd17, 64'h77, ep, em);
    @(negedge clock);
    checks++;
    if (dut.starve_cnt !== 4'd3) begin
      errors++; $display("[TB] FAIL mid_starve_pre: got %0d, expected 3", dut.starve_cnt);
    end
    drive_reset();
    checks += 2;
    if (p_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_p_ready: got %b, expected 0", p_ready);
    end
    if (m_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_m_ready: got %b, expected 0", m_ready);
    end
    @(posedge clock); #2;
    checks += 3;
    if (wb_valid !== 1'b0 || wb_commit !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_wb: got valid=%b commit=%b, expected 0/0", wb_valid, wb_commit);
    end
    if (wb_dest_addr !== 5'd0) begin
      errors++; $display("[TB] FAIL mid_addr: got %0d, expected 0", wb_dest_addr);
    end
    if (dut.starve_cnt !== 4'd0) begin
      errors++; $display("[TB] FAIL mid_starve: got %0d, expected 0", dut.starve_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic ep, em, pv, mv;
    logic [4:0] mrd;
    idle(1);
    for (int c = 0; c < 40; c++) begin
      pv  = 1'($urandom_range(0, 3) != 0);
      mv  = 1'($urandom_range(0, 1));
      mrd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
      drive_cycle(pv, 5'($urandom_range(1, 15)), {$urandom, $urandom}, mv, mrd, {$urandom, $urandom}, ep, em);
      checks++;
      if (p_ready !== ep || m_ready !== em) begin
        errors++; $display("[TB] FAIL b2b_ready c%0d: got p=%b m=%b, expected p=%b m=%b", c, p_ready, m_ready, ep, em);
      end
    end
    idle(2);
  endtask

`ifdef WB_ARB_PERF_EN
  task automatic test_perf();
    logic ep, em;
    drive_reset();
    for (int c = 0; c < 10; c++) drive_cycle(1, 5'(10 + c), 64'(c), 1, 5'd9, 64'h99, ep, em);
    drive_cycle(0, 5'd0, '0, 0, 5'd0, '0, ep, em);
    checks += 2;
    if (perf_conflict_cnt !== model_conflict || perf_conflict_cnt !== 64'd10) begin
      errors++; $display("[TB] FAIL perf_conflict: got %0d, expected 10", perf_conflict_cnt);
    end
    if (perf_force_cnt !== model_force || perf_force_cnt !== 64'd2) begin
      errors++; $display("[TB] FAIL perf_force: got %0d, expected 2", perf_force_cnt);
    end
    idle(1);
  endtask
`endif

  initial begin
    test_reset();
    test_single_p();
    test_rd_zero();
    test_conflict();
    test_m_drop();
    test_reset_mid();
    test_back_to_back();
`ifdef WB_ARB_PERF_EN
    test_perf();
`endif
    idle(1);
    @(posedge clock); #3;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
